fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BUBBLE, default 32'h0000_0000: instruction word placed in decode on flush or bubble.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 StallF  input  1  hold PC and fetch state (hazard unit).
REQ-006 StallD  input  1  hold the IF/ID register (hazard unit).
REQ-007 FlushD  input  1  clear the IF/ID register to bubble (hazard unit).
REQ-008 PCSrcE  input  1  redirect fetch to PCTargetE (from the pipeline controller).
REQ-009 PCTargetE  input  32  branch/jump target.
REQ-010 imem_req  output  1  instruction-memory request.
REQ-011 imem_addr  output  32  request address; stable while imem_req=1 and no imem_valid.
REQ-012 imem_valid  input  1  response strobe, arriving 1 or more cycles after imem_req rises.
REQ-013 imem_rdata  input  32  instruction word; valid when imem_valid=1.
REQ-014 InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents.
REQ-015 ValidD  output  1  IF/ID holds a real instruction.
REQ-016 opcode [6:0], f3 [14:12], f7 [31:25]  output  slices of InstrD, feeding the pipeline controller.

Function
REQ-017 SHALL keep registers PCF (next fetch PC), reqaddr, bufinstr, and FSM state in {FETCH, DROP, HELD}.
REQ-018 FETCH: imem_req=1, imem_addr=PCF; reqaddr<=PCF each cycle it is in FETCH.
REQ-019 FETCH, imem_valid=1, PCSrcE=0, StallF=0, StallD=0: IF/ID<={imem_rdata, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4 (mod 2^32), stay FETCH.
REQ-020 FETCH, imem_valid=1, (StallF|StallD)=1, PCSrcE=0: bufinstr<=imem_rdata, go HELD, PCF unchanged.
REQ-021 FETCH, imem_valid=0, PCSrcE=1: PCF<=PCTargetE, go DROP (stale response outstanding).
REQ-022 FETCH, imem_valid=1, PCSrcE=1: discard response, PCF<=PCTargetE, stay FETCH.
REQ-023 DROP: imem_req=1, imem_addr=reqaddr; on imem_valid, discard response and go FETCH; PCSrcE in DROP only overwrites PCF with PCTargetE.
REQ-024 HELD: imem_req=0; when StallF=0 and StallD=0, load IF/ID from {bufinstr, PCF, PCF+4}, PCF<=PCF+4, go FETCH.
REQ-025 HELD, PCSrcE=1: drop bufinstr, PCF<=PCTargetE, go FETCH; PCSrcE has priority over stall release.
REQ-026 IF/ID priority per cycle: reset > FlushD (InstrD<=BUBBLE, ValidD<=0, PCD/PCPlus4D<=0) > StallD (hold) > load per REQ-019/024 > otherwise bubble (InstrD<=BUBBLE, ValidD<=0).
REQ-027 FlushD SHALL not alter PCF or FSM state; only PCSrcE redirects.
REQ-028 Fetch latency: imem_valid in cycle n SHALL make InstrD valid in cycle n+1 when unstalled.
REQ-029 imem_req SHALL never be deasserted with a response outstanding (FETCH->HELD only on imem_valid).
REQ-030 PC arithmetic SHALL wrap 32'hFFFF_FFFC+4 to 0; no alignment check.

Reset
REQ-031 On reset: PCF=RESET_PC, state=FETCH, InstrD=BUBBLE, PCD=PCPlus4D=0, ValidD=0, bufinstr=0.
REQ-032 Reset mid-request SHALL drop any outstanding response; instruction memory resets from the same reset and aborts.
REQ-033 First cycle after reset deassertion SHALL drive imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory, words 0x00500093, 0x00100113 at 0x0, 0x4 -> InstrD sequence 0x00500093 (PCD=0), 0x00100113 (PCD=4), ValidD=1.
REQ-035 imem_valid 3 cycles late for addr 0x8 -> imem_addr held at 0x8 all cycles, InstrD=BUBBLE/ValidD=0 meanwhile, then PCD=0x8.
REQ-036 PCSrcE=1, PCTargetE=0x40 while 0x10 outstanding -> DROP, 0x10 response discarded, next request addr 0x40, PCD=0x40 next loaded.
REQ-037 StallD=1 on response for 0xC, held 2 cycles -> HELD, imem_req=0, IF/ID unchanged, on release PCD=0xC, next request 0x10.
REQ-038 FlushD=1 with PCSrcE=1 and imem_valid same cycle -> InstrD=BUBBLE, ValidD=0, response discarded, next imem_addr=PCTargetE.
REQ-039 reset asserted in DROP -> next cycle state FETCH, imem_addr=RESET_PC, ValidD=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// The master side issues requests; the slave side returns a word on imem_valid.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, request FSM tracking an outstanding imem access,
// and the IF/ID pipeline register with stall/flush/bubble handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output logic [6:0]           opcode,
  output logic [2:0]           f3,
  output logic [6:0]           f7
);

  typedef enum logic [1:0] {StFetch, StDrop, StHeld} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] reqaddr_q, reqaddr_d;
  logic [31:0] bufinstr_q, bufinstr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;

  assign pc_plus4 = pcf_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    reqaddr_d  = reqaddr_q;
    bufinstr_d = bufinstr_q;
    load       = 1'b0;
    load_instr = bufinstr_q;
    imem_req   = 1'b1;
    imem_addr  = pcf_q;
    unique case (state_q)
      StFetch: begin
        reqaddr_d = pcf_q;
        if (imem.imem_valid) begin
          if (PCSrcE) begin
            pcf_d = PCTargetE;
          end else if (StallF || StallD) begin
            bufinstr_d = imem.imem_rdata;
            state_d    = StHeld;
          end else begin
            load       = 1'b1;
            load_instr = imem.imem_rdata;
            pcf_d      = pc_plus4;
          end
        end else if (PCSrcE) begin
          // Response for the old PC is still in flight; it must be swallowed in StDrop.
          pcf_d   = PCTargetE;
          state_d = StDrop;
        end
      end
      StDrop: begin
        imem_addr = reqaddr_q;
        if (PCSrcE) pcf_d = PCTargetE;
        if (imem.imem_valid) state_d = StFetch;
      end
      StHeld: begin
        imem_req  = 1'b0;
        imem_addr = reqaddr_q;
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = StFetch;
        end else if (!StallF && !StallD) begin
          load    = 1'b1;
          pcf_d   = pc_plus4;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (FlushD) begin
      instr_d   = BUBBLE;
      valid_d   = 1'b0;
      pcd_d     = 32'd0;
      pcplus4_d = 32'd0;
    end else if (StallD) begin
      // hold
    end else if (load) begin
      instr_d   = load_instr;
      pcd_d     = pcf_q;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end else begin
      instr_d = BUBBLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pcf_q      <= RESET_PC;
      reqaddr_q  <= RESET_PC;
      bufinstr_q <= 32'd0;
      instr_q    <= BUBBLE;
      pcd_q      <= 32'd0;
      pcplus4_q  <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      reqaddr_q  <= reqaddr_d;
      bufinstr_q <= bufinstr_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcplus4_q  <= pcplus4_d;
      valid_q    <= valid_d;
    end
  end

  assign imem.imem_req  = imem_req;
  assign imem.imem_addr = imem_addr;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4_q;
  assign ValidD   = valid_q;
  assign opcode   = instr_q[6:0];
  assign f3       = instr_q[14:12];
  assign f7       = instr_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one row per clock cycle, plus a short
// zero-wait streaming sequence driven from a tiny memory model.
module tb_fetch_stage;

  localparam logic [31:0] B = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .opcode    (opcode),
    .f3        (f3),
    .f7        (f7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stf, std, fld, pcs;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] rd;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vd;
    logic [31:0] e_instr;
    logic        chk_pc;
    logic [31:0] e_pcd, e_pc4;
  } vec_t;

  function automatic vec_t mk(logic rst, logic stf, logic std, logic fld, logic pcs,
                              logic [31:0] tgt, logic vld, logic [31:0] rd,
                              logic chk, logic e_req, logic [31:0] e_addr, logic e_vd,
                              logic [31:0] e_instr, logic chk_pc, logic [31:0] e_pcd,
                              logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.stf = stf; v.std = std; v.fld = fld; v.pcs = pcs; v.tgt = tgt;
    v.vld = vld; v.rd = rd; v.chk = chk; v.e_req = e_req; v.e_addr = e_addr;
    v.e_vd = e_vd; v.e_instr = e_instr; v.chk_pc = chk_pc; v.e_pcd = e_pcd; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  vec_t vecs[26];

  initial begin
    logic [31:0] pc;
    logic [31:0] ei;
    // reset; zero-wait fetch of two words
    vecs[0]  = mk(1,0,0,0,0, 0, 0, 0,             0,0,0,0,0,            0,0,0);
    vecs[1]  = mk(0,0,0,0,0, 0, 1, 32'h00500093,  1,1,0,0,B,            1,0,0);
    vecs[2]  = mk(0,0,0,0,0, 0, 1, 32'h00100113,  1,1,4,1,32'h00500093, 1,0,4);
    // response for 0x8 three cycles late
    vecs[3]  = mk(0,0,0,0,0, 0, 0, 0,             1,1,8,1,32'h00100113, 1,4,8);
    vecs[4]  = mk(0,0,0,0,0, 0, 0, 0,             1,1,8,0,B,            0,0,0);
    vecs[5]  = mk(0,0,0,0,0, 0, 0, 0,             1,1,8,0,B,            0,0,0);
    vecs[6]  = mk(0,0,0,0,0, 0, 1, 32'hAAAA0001,  1,1,8,0,B,            0,0,0);
    // StallD on response for 0xC, held two cycles, then released
    vecs[7]  = mk(0,0,1,0,0, 0, 1, 32'hBBBB0002,  1,1,32'hC,1,32'hAAAA0001, 1,8,32'hC);
    vecs[8]  = mk(0,0,1,0,0, 0, 0, 0,             1,0,0,1,32'hAAAA0001, 1,8,32'hC);
    vecs[9]  = mk(0,0,1,0,0, 0, 0, 0,             1,0,0,1,32'hAAAA0001, 1,8,32'hC);
    vecs[10] = mk(0,0,0,0,0, 0, 0, 0,             1,0,0,1,32'hAAAA0001, 1,8,32'hC);
    // redirect to 0x40 while 0x10 outstanding
    vecs[11] = mk(0,0,0,0,1, 32'h40, 0, 0,        1,1,32'h10,1,32'hBBBB0002, 1,32'hC,32'h10);
    vecs[12] = mk(0,0,0,0,0, 0, 0, 0,             1,1,32'h10,0,B,       0,0,0);
    vecs[13] = mk(0,0,0,0,0, 0, 1, 32'hDEAD0010,  1,1,32'h10,0,B,       0,0,0);
    vecs[14] = mk(0,0,0,0,0, 0, 1, 32'h12340040,  1,1,32'h40,0,B,       0,0,0);
    // FlushD + PCSrcE + imem_valid in one cycle
    vecs[15] = mk(0,0,0,1,1, 32'h80, 1, 32'h55550044, 1,1,32'h44,1,32'h12340040,
                  1,32'h40,32'h44);
    vecs[16] = mk(0,0,0,0,1, 32'h100, 0, 0,       1,1,32'h80,0,B,       1,0,0);
    // reset while in DROP
    vecs[17] = mk(1,0,0,0,0, 0, 0, 0,             1,1,32'h80,0,B,       0,0,0);
    vecs[18] = mk(0,0,0,0,0, 0, 0, 0,             1,1,0,0,B,            1,0,0);
    // PC wrap at 0xFFFF_FFFC
    vecs[19] = mk(0,0,0,0,1, 32'hFFFFFFFC, 1, 0,  1,1,0,0,B,            0,0,0);
    vecs[20] = mk(0,0,0,0,0, 0, 1, 32'h77770000,  1,1,32'hFFFFFFFC,0,B, 0,0,0);
    vecs[21] = mk(0,0,0,0,0, 0, 0, 0,             1,1,0,1,32'h77770000, 1,32'hFFFFFFFC,0);
    // StallF into HELD, then PCSrcE beats release
    vecs[22] = mk(0,1,0,0,0, 0, 1, 32'h99990000,  1,1,0,0,B,            0,0,0);
    vecs[23] = mk(0,0,0,0,1, 32'h200, 0, 0,       1,0,0,0,B,            0,0,0);
    vecs[24] = mk(0,0,0,0,0, 0, 1, 32'h0BAD0200,  1,1,32'h200,0,B,      0,0,0);
    vecs[25] = mk(0,0,0,0,0, 0, 0, 0,             1,1,32'h204,1,32'h0BAD0200,
                  1,32'h200,32'h204);

    for (int i = 0; i < 26; i++) begin
      reset                = vecs[i].rst;
      StallF               = vecs[i].stf;
      StallD               = vecs[i].std;
      FlushD               = vecs[i].fld;
      PCSrcE               = vecs[i].pcs;
      PCTargetE            = vecs[i].tgt;
      imem_bus.imem_valid  = vecs[i].vld;
      imem_bus.imem_rdata  = vecs[i].rd;
      #1;
      if (vecs[i].chk) begin
        ei = vecs[i].e_instr;
        cmp($sformatf("row%0d imem_req", i), {31'd0, imem_bus.imem_req}, {31'd0, vecs[i].e_req});
        if (vecs[i].e_req)
          cmp($sformatf("row%0d imem_addr", i), imem_bus.imem_addr, vecs[i].e_addr);
        cmp($sformatf("row%0d ValidD", i), {31'd0, ValidD}, {31'd0, vecs[i].e_vd});
        cmp($sformatf("row%0d InstrD", i), InstrD, ei);
        cmp($sformatf("row%0d fields", i), {15'd0, f7, f3, opcode}, {15'd0, ei[31:25], ei[14:12], ei[6:0]});
        if (vecs[i].chk_pc) begin
          cmp($sformatf("row%0d PCD", i), PCD, vecs[i].e_pcd);
          cmp($sformatf("row%0d PCPlus4D", i), PCPlus4D, vecs[i].e_pc4);
        end
      end
      @(posedge clk);
      #1;
    end

    // zero-wait streaming from a small memory model, starting at 0x204
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    pc = 32'h204;
    for (int k = 0; k < 4; k++) begin
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = mem_word(pc);
      #1;
      cmp($sformatf("stream%0d imem_addr", k), imem_bus.imem_addr, pc);
      @(posedge clk);
      #1;
      cmp($sformatf("stream%0d ValidD", k), {31'd0, ValidD}, 32'd1);
      cmp($sformatf("stream%0d InstrD", k), InstrD, mem_word(pc));
      cmp($sformatf("stream%0d PCD", k), PCD, pc);
      pc = pc + 32'd4;
    end
    imem_bus.imem_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
